// File: rtl/apb_uart_lite.sv
// APB UART: one-entry TX/RX holding registers, 8x-oversampled baud scaler, optional parity and CTS/RTS flow control.
// Zero-wait-state APB access; the LB loopback bit exists only when APBUART_LOOPBACK_EN is defined.
`timescale 1ns/1ps
module apb_uart_lite #(
  parameter int const_pindex   = 0,
  parameter int const_paddr    = 0,
  parameter int const_pmask    = 12'hfff,
  parameter int const_console  = 0,
  parameter int const_pirq     = 0,
  parameter int const_parity   = 1,
  parameter int const_flow     = 1,
  parameter int const_fifosize = 1,
  parameter int const_abits    = 8,
  parameter int const_sbits    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [31:0] pirq_i,
  input  logic        testen,
  input  logic        testrst,
  input  logic        scanen,
  input  logic        testoen,
  input  logic [3:0]  testin,
  output logic [31:0] prdata,
  output logic [31:0] pirq_o,
  output logic [1:0]  pconfig,
  output logic [31:0] pindex,
  input  logic        rxd,
  input  logic        ctsn,
  input  logic        extclk,
  output logic        rtsn,
  output logic        txd,
  output logic        scaler,
  output logic        txen,
  output logic        rxen,
  output logic        flow,
  output logic        txtick,
  output logic        rxtick
);

  localparam logic CONSOLE  = (const_console != 0);
  localparam logic HAS_PAR  = (const_parity != 0);
  localparam logic HAS_FLOW = (const_flow != 0);

  logic       sel, wr, rd;
  logic [1:0] reg_addr;
  logic       re, te, ri, ti, ps, pen, fl, lb, ec;
  logic [const_sbits-1:0] reload, scnt;
  logic       dr, br, ov, perr, fe, thr_full;
  logic [7:0] thr, rx_data;
  logic       rxd_s1, rxd_s2, cts_s1, cts_s2, ext_s1, ext_s2, ext_s3;
  logic       scnt_en, tick;
  logic       tx_busy, txd_q, tx_start, thr_wr;
  logic [9:0] tx_sr;
  logic [3:0] tx_left;
  logic [2:0] tx_tcnt;
  logic       rx_busy, rx_prev, rx_par, rx_line, rx_sample, rx_done;
  logic [3:0] rx_idx, rx_last;
  logic [2:0] rx_tcnt;
  logic [7:0] rx_sr;
  logic       rx_fe, rx_pe, rx_br, dr_rd, st_wr, irq_q;

  assign sel      = psel[const_pindex];
  assign reg_addr = paddr[3:2];
  assign wr       = sel & penable & pwrite;
  assign rd       = sel & penable & ~pwrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1 <= 1'b1; rxd_s2 <= 1'b1;
      cts_s1 <= 1'b1; cts_s2 <= 1'b1;
      ext_s1 <= 1'b0; ext_s2 <= 1'b0; ext_s3 <= 1'b0;
    end else begin
      rxd_s1 <= rxd;    rxd_s2 <= rxd_s1;
      cts_s1 <= ctsn;   cts_s2 <= cts_s1;
      ext_s1 <= extclk; ext_s2 <= ext_s1; ext_s3 <= ext_s2;
    end
  end

  // Oversample tick: divider advances every clk, or per synchronized extclk rise when EC=1.
  assign scnt_en = ec ? (ext_s2 & ~ext_s3) : 1'b1;
  assign tick    = scnt_en & (scnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt   <= '0;
      scaler <= 1'b0;
    end else begin
      scaler <= tick;
      if (scnt_en) scnt <= tick ? reload : scnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re <= CONSOLE; te <= CONSOLE;
      ri <= 1'b0; ti <= 1'b0; ps <= 1'b0; pen <= 1'b0; fl <= 1'b0; ec <= 1'b0;
      reload <= '0;
    end else if (wr && reg_addr == 2'd2) begin
      re  <= pwdata[0];
      te  <= pwdata[1];
      ri  <= pwdata[2];
      ti  <= pwdata[3];
      ps  <= pwdata[4] & HAS_PAR;
      pen <= pwdata[5] & HAS_PAR;
      fl  <= pwdata[6] & HAS_FLOW;
      ec  <= pwdata[8];
    end else if (wr && reg_addr == 2'd3) begin
      reload <= pwdata[const_sbits-1:0];
    end
  end

`ifdef APBUART_LOOPBACK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          lb <= 1'b0;
    else if (wr && reg_addr == 2'd2)   lb <= pwdata[7];
  end
`else
  assign lb = 1'b0;
`endif

  // Frames launch on a tick so every bit, including start, lasts exactly 8 ticks.
  assign thr_wr   = wr & (reg_addr == 2'd0);
  assign tx_start = tick & te & thr_full & ~tx_busy & (~fl | ~cts_s2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr      <= '0;
      thr_full <= 1'b0;
      tx_busy  <= 1'b0;
      tx_sr    <= '0;
      tx_left  <= '0;
      tx_tcnt  <= '0;
      txd_q    <= 1'b1;
      txtick   <= 1'b0;
    end else begin
      txtick <= 1'b0;
      if (thr_wr) begin
        thr      <= pwdata[7:0];
        thr_full <= 1'b1;
      end else if (tx_start) begin
        thr_full <= 1'b0;
      end
      if (tx_start) begin
        tx_busy <= 1'b1;
        txd_q   <= 1'b0;
        txtick  <= 1'b1;
        tx_tcnt <= '0;
        tx_sr   <= {1'b1, pen ? (ps ^ (^thr)) : 1'b1, thr};
        tx_left <= pen ? 4'd10 : 4'd9;
      end else if (tx_busy && tick) begin
        tx_tcnt <= tx_tcnt + 1'b1;
        if (tx_tcnt == 3'd7) begin
          if (tx_left != 4'd0) begin
            txd_q   <= tx_sr[0];
            tx_sr   <= {1'b1, tx_sr[9:1]};
            tx_left <= tx_left - 1'b1;
            txtick  <= 1'b1;
          end else begin
            tx_busy <= 1'b0;
            txd_q   <= 1'b1;
          end
        end
      end
    end
  end

  // Bit index: 0 start, 1..8 data, 9 parity when enabled, then stop.
  assign rx_line   = lb ? txd_q : rxd_s2;
  assign rx_last   = pen ? 4'd10 : 4'd9;
  assign rx_sample = rx_busy & tick & (rx_tcnt == 3'd3);
  assign rx_done   = rx_sample & (rx_idx == rx_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_busy <= 1'b0;
      rx_prev <= 1'b1;
      rx_idx  <= '0;
      rx_tcnt <= '0;
      rx_sr   <= '0;
      rx_par  <= 1'b0;
      rxtick  <= 1'b0;
    end else begin
      rx_prev <= rx_line;
      rxtick  <= rx_sample;
      if (!rx_busy) begin
        if (re && rx_prev && !rx_line) begin
          rx_busy <= 1'b1;
          rx_idx  <= '0;
          rx_tcnt <= '0;
        end
      end else if (tick) begin
        rx_tcnt <= rx_tcnt + 1'b1;
        if (rx_tcnt == 3'd3) begin
          rx_idx <= rx_idx + 1'b1;
          if (rx_idx == 4'd0) begin
            if (rx_line) rx_busy <= 1'b0;
          end else if (rx_idx <= 4'd8) begin
            rx_sr <= {rx_line, rx_sr[7:1]};
          end else if (rx_idx == rx_last) begin
            rx_busy <= 1'b0;
          end else begin
            rx_par <= rx_line;
          end
        end
      end
    end
  end

  assign rx_fe = ~rx_line;
  assign rx_pe = pen & (rx_par != (ps ^ (^rx_sr)));
  assign rx_br = rx_fe & (rx_sr == 8'd0) & (~pen | ~rx_par);
  assign dr_rd = rd & (reg_addr == 2'd0);
  assign st_wr = wr & (reg_addr == 2'd1);

  // Set beats clear: a frame completing during a data read or W1C leaves the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr <= 1'b0; br <= 1'b0; ov <= 1'b0; perr <= 1'b0; fe <= 1'b0;
      rx_data <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= (ri & rx_done) | (ti & tx_start & ~thr_wr);
      if (st_wr) begin
        if (pwdata[3]) br   <= 1'b0;
        if (pwdata[4]) ov   <= 1'b0;
        if (pwdata[5]) perr <= 1'b0;
        if (pwdata[6]) fe   <= 1'b0;
      end
      if (dr_rd) dr <= 1'b0;
      if (rx_done) begin
        if (dr) ov <= 1'b1;
        else    rx_data <= rx_sr;
        dr <= 1'b1;
        if (rx_fe) fe   <= 1'b1;
        if (rx_br) br   <= 1'b1;
        if (rx_pe) perr <= 1'b1;
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (sel) begin
      case (reg_addr)
        2'd0:    prdata[7:0] = rx_data;
        2'd1:    prdata[6:0] = {fe, perr, ov, br, ~thr_full, ~tx_busy, dr};
        2'd2:    prdata[8:0] = {ec, lb, fl, pen, ps, ti, ri, te, re};
        default: prdata[const_sbits-1:0] = reload;
      endcase
    end
  end

  always_comb begin
    pirq_o = '0;
    pirq_o[const_pirq] = irq_q;
  end

  assign pconfig = 2'b11;
  assign pindex  = 32'(const_pindex);
  assign txd     = txd_q;
  assign rtsn    = fl & dr;
  assign txen    = te;
  assign rxen    = re;
  assign flow    = fl;

  logic unused_ok;
  assign unused_ok = ^{pirq_i, testen, testrst, scanen, testoen, testin, paddr, pwdata,
                       32'(const_paddr), 32'(const_pmask), 32'(const_fifosize), 32'(const_abits)};

endmodule

// File: tb/tb_apb_uart_lite.sv
// Bench for apb_uart_lite: register vector table, TX frame scoreboard, RX byte scoreboard, flow/irq sequences.
`timescale 1ns/1ps
module tb_apb_uart_lite;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] psel = '0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, pirq_i = '0;
  logic        testen = 1'b0, testrst = 1'b0, scanen = 1'b0, testoen = 1'b0;
  logic [3:0]  testin = '0;
  logic        rxd = 1'b1, ctsn = 1'b0, extclk = 1'b0;
  logic [31:0] prdata, pirq_o, pindex;
  logic [1:0]  pconfig;
  logic        rtsn, txd, scaler, txen, rxen, flow, txtick, rxtick;

  always #5 clk = ~clk;

  apb_uart_lite dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pirq_i(pirq_i), .testen(testen), .testrst(testrst), .scanen(scanen),
    .testoen(testoen), .testin(testin), .prdata(prdata), .pirq_o(pirq_o), .pconfig(pconfig),
    .pindex(pindex), .rxd(rxd), .ctsn(ctsn), .extclk(extclk), .rtsn(rtsn), .txd(txd),
    .scaler(scaler), .txen(txen), .rxen(rxen), .flow(flow), .txtick(txtick), .rxtick(rxtick)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct { logic [10:0] bits; int n; } frame_t;
  typedef struct { bit sel; bit wr; logic [3:0] addr; logic [31:0] wdata; logic [31:0] exp; string name; } vec_t;

  frame_t     tx_q[$];
  logic [7:0] rx_q[$];
  vec_t       vt[$];
  bit         mon_busy = 1'b0;

  function automatic frame_t mk_frame(input logic [7:0] d, input bit pe, input bit odd);
    frame_t f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    f.bits = 11'b0;
    f.bits[8:1] = d;
    if (pe) begin
      f.bits[9]  = (ones % 2 == 1) ? ~odd : odd;
      f.bits[10] = 1'b1;
      f.n = 11;
    end else begin
      f.bits[9] = 1'b1;
      f.n = 10;
    end
    return f;
  endfunction

  task automatic addv(input bit s, input bit w, input logic [3:0] a, input logic [31:0] wd,
                      input logic [31:0] e, input string n);
    vec_t v;
    v.sel = s; v.wr = w; v.addr = a; v.wdata = wd; v.exp = e; v.name = n;
    vt.push_back(v);
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); psel = 16'h0001; paddr = {28'h0, a}; pwrite = 1'b1; pwdata = d; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = '0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, input bit s, output logic [31:0] d);
    @(negedge clk); psel = {15'h0, s}; paddr = {28'h0, a}; pwrite = 1'b0; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    #1 d = prdata;
    @(negedge clk); psel = '0; penable = 1'b0;
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [31:0] e, input string name);
    logic [31:0] d;
    apb_read(a, 1'b1, d);
    check(name, d, e);
  endtask

  task automatic read_rx(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    apb_read(4'h0, 1'b1, d);
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check(name, d, {24'h0, e});
  endtask

  task automatic wait_txd(input logic v, input int budget, input string name);
    int k;
    k = 0;
    while (txd !== v && k < budget) begin @(negedge clk); k++; end
    check(name, {31'b0, txd}, {31'b0, v});
  endtask

  task automatic wait_tx_done(input string name);
    int k;
    k = 0;
    while ((tx_q.size() != 0 || mon_busy) && k < 3000) begin @(negedge clk); k++; end
    check({name, "_drain"}, tx_q.size() + int'(mon_busy), 0);
    repeat (40) @(negedge clk);
    check_reg(4'h4, 32'h6, {name, "_idle"});
  endtask

  task automatic drive_rx(input logic [7:0] d, input bit pe, input bit bad_par, input bit stop);
    frame_t f;
    f = mk_frame(d, pe, 1'b0);
    if (bad_par) f.bits[9] = ~f.bits[9];
    f.bits[f.n-1] = stop;
    for (int i = 0; i < f.n; i++) begin
      rxd = f.bits[i];
      repeat (32) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  // TX scoreboard: sample each bit at mid-bit (32 clk per bit at scaler=3).
  initial begin : tx_mon
    logic   prev;
    frame_t got, e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && prev && !txd) begin
        mon_busy = 1'b1;
        if (tx_q.size() > 0) e = tx_q.pop_front();
        else begin e.bits = 11'h7ff; e.n = 10; end
        got.bits = 11'b0;
        repeat (15) @(negedge clk);
        for (int i = 0; i < e.n; i++) begin
          got.bits[i] = txd;
          if (i < e.n - 1) repeat (32) @(negedge clk);
        end
        check("tx_frame", {21'h0, got.bits}, {21'h0, e.bits});
        mon_busy = 1'b0;
      end
      prev = txd;
    end
  end

  int irq_pulses = 0, irq_hi = 0, tx_ticks = 0, rx_ticks = 0;
  initial begin : pulse_mon
    logic prev_irq;
    prev_irq = 1'b0;
    forever begin
      @(negedge clk);
      if (pirq_o[0]) irq_hi++;
      if (pirq_o[0] && !prev_irq) irq_pulses++;
      prev_irq = pirq_o[0];
      if (txtick) tx_ticks++;
      if (rxtick) rx_ticks++;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    logic [31:0] ctrl_all;
    int cnt, p0, t0;
`ifdef APBUART_LOOPBACK_EN
    ctrl_all = 32'h1FF;
`else
    ctrl_all = 32'h17F;
`endif
    repeat (3) @(negedge clk);
    check("reset_outs", {24'h0, txd, rtsn, scaler, txtick, rxtick, txen, rxen, flow}, 32'h80);
    check("reset_irq", pirq_o, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("pconfig", {30'h0, pconfig}, 32'h3);
    check("pindex", pindex, 32'h0);

    addv(1, 1, 4'h4, 32'hFFFFFFFF, 0,        "status_w1c");
    addv(1, 0, 4'h4, 0,            32'h6,    "status_reset");
    addv(1, 0, 4'h0, 0,            32'h0,    "data_reset");
    addv(1, 0, 4'h8, 0,            32'h0,    "ctrl_reset");
    addv(1, 0, 4'hC, 0,            32'h0,    "scaler_reset");
    addv(1, 1, 4'hC, 32'hFFFFFFFF, 0,        "scaler_wr");
    addv(1, 0, 4'hC, 0,            32'hFFF,  "scaler_width");
    addv(1, 1, 4'h8, 32'hFFFFFFFF, 0,        "ctrl_wr");
    addv(1, 0, 4'h8, 0,            ctrl_all, "ctrl_all");
    addv(0, 0, 4'h8, 0,            32'h0,    "deselected_read");
    addv(1, 1, 4'h8, 32'h0,        0,        "ctrl_clr");
    addv(1, 0, 4'h8, 0,            32'h0,    "ctrl_cleared");
    addv(1, 1, 4'hC, 32'h3,        0,        "scaler_3");
    addv(1, 0, 4'hC, 0,            32'h3,    "scaler_readback");
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) apb_write(vt[i].addr, vt[i].wdata);
      else begin
        apb_read(vt[i].addr, vt[i].sel, d);
        check(vt[i].name, d, vt[i].exp);
      end
    end

    // Plain 8N1 frame, bit timing and tick count.
    apb_write(4'h8, 32'h3);
    t0 = tx_ticks;
    tx_q.push_back(mk_frame(8'h55, 1'b0, 1'b0));
    apb_write(4'h0, 32'h55);
    wait_txd(1'b0, 6000, "tx_start");
    cnt = 0;
    while (txd === 1'b0 && cnt < 100) begin @(negedge clk); cnt++; end
    check("start_bit_clks", cnt, 32);
    cnt = 0;
    while (txd === 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
    check("bit0_clks", cnt, 32);
    wait_tx_done("tx_55");
    check("txtick_count", tx_ticks - t0, 10);

    // Even then odd parity.
    apb_write(4'h8, 32'h23);
    tx_q.push_back(mk_frame(8'h55, 1'b1, 1'b0));
    apb_write(4'h0, 32'h55);
    wait_tx_done("tx_even");
    apb_write(4'h8, 32'h33);
    tx_q.push_back(mk_frame(8'h03, 1'b1, 1'b1));
    apb_write(4'h0, 32'h03);
    wait_tx_done("tx_odd");

    // TX-empty interrupt.
    apb_write(4'h8, 32'h0A);
    p0 = irq_pulses;
    tx_q.push_back(mk_frame(8'h81, 1'b0, 1'b0));
    apb_write(4'h0, 32'h81);
    wait_tx_done("tx_ti");
    check("ti_irq", irq_pulses - p0, 1);

    // CTS holds the frame until ctsn drops.
    ctsn = 1'b1;
    apb_write(4'h8, 32'h42);
    tx_q.push_back(mk_frame(8'h3C, 1'b0, 1'b0));
    apb_write(4'h0, 32'h3C);
    cnt = 0;
    repeat (200) begin @(negedge clk); if (!txd) cnt++; end
    check("cts_hold_txd", cnt, 0);
    check_reg(4'h4, 32'h2, "cts_thr_full");
    ctsn = 1'b0;
    wait_txd(1'b0, 50, "cts_release");
    wait_tx_done("tx_cts");

    // Receive with RI interrupt.
    apb_write(4'h8, 32'h07);
    p0 = irq_pulses;
    t0 = rx_ticks;
    rx_q.push_back(8'hA5);
    drive_rx(8'hA5, 1'b0, 1'b0, 1'b1);
    check_reg(4'h4, 32'h7, "rx_dr_set");
    check("ri_irq", irq_pulses - p0, 1);
    check("rxtick_count", rx_ticks - t0, 10);
    read_rx("rx_a5");
    check_reg(4'h4, 32'h6, "rx_dr_cleared");

    // Overrun keeps the first byte.
    rx_q.push_back(8'h11);
    drive_rx(8'h11, 1'b0, 1'b0, 1'b1);
    drive_rx(8'h22, 1'b0, 1'b0, 1'b1);
    check_reg(4'h4, 32'h17, "ov_status");
    read_rx("ov_first_byte");
    apb_write(4'h4, 32'h10);
    check_reg(4'h4, 32'h6, "ov_cleared");

    // Break with flow control: FE+BR, rtsn follows DR.
    apb_write(4'h8, 32'h47);
    rx_q.push_back(8'h00);
    drive_rx(8'h00, 1'b0, 1'b0, 1'b0);
    check("rtsn_dr", {31'h0, rtsn}, 32'h1);
    check_reg(4'h4, 32'h4F, "break_status");
    read_rx("break_byte");
    check("rtsn_clear", {31'h0, rtsn}, 32'h0);
    apb_write(4'h4, 32'h48);
    check_reg(4'h4, 32'h6, "fe_br_cleared");

    // Parity error then a clean parity frame.
    apb_write(4'h8, 32'h27);
    rx_q.push_back(8'h5A);
    drive_rx(8'h5A, 1'b1, 1'b1, 1'b1);
    check_reg(4'h4, 32'h27, "parity_err");
    read_rx("parity_err_byte");
    apb_write(4'h4, 32'h20);
    rx_q.push_back(8'h3C);
    drive_rx(8'h3C, 1'b1, 1'b0, 1'b1);
    check_reg(4'h4, 32'h7, "parity_ok");
    read_rx("parity_ok_byte");

    check("irq_width", irq_hi, irq_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_uart_lite.md
# apb_uart_lite

APB-attached asynchronous serial port (UART) with a single-entry transmit and receive holding register, optional parity and CTS/RTS flow control. It sits on a peripheral APB bus behind the system APB decoder. It is selected by one bit of the slave-select vector and raises one interrupt line of the system IRQ vector. Accesses have zero wait states.

## Interface
- const_pindex, 0: slave index; selects psel bit and pirq_o index base info.
- const_paddr, 0: base address, reported in pconfig only.
- const_pmask, 12'hfff: address mask, reported in pconfig only.
- const_console, 0: 1 = control TE/RE reset to 1.
- const_pirq, 0: pirq_o bit driven.
- const_parity, 1: 0 = parity logic removed, PE/PS read 0.
- const_flow, 1: 0 = flow control removed, FL reads 0.
- const_fifosize, 1: only 1 supported.
- const_abits, 8: paddr bits decoded (register = paddr[3:2]).
- const_sbits, 12: scaler width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- psel  in  16  slave selects; this block uses psel[const_pindex].
- penable  in  1  APB access phase.
- paddr  in  32  byte address.
- pwrite  in  1  1 = write.
- pwdata  in  32  write data.
- pirq_i  in  32  ignored.
- testen, testrst, scanen, testoen  in  1 each  ignored.
- testin  in  4  ignored.
- prdata  out  32  read data.
- pirq_o  out  32  interrupt vector; only bit const_pirq used.
- pconfig  out  2  bit1 = 1 (device present); bit0 = 1 (interrupt capable).
- pindex  out  32 (integer)  constant const_pindex.
- rxd, ctsn, extclk  in  1  serial in, clear-to-send (low active), external baud clock.
- rtsn, txd  out  1  request-to-send (low active), serial out.
- scaler  out  1  one-cycle pulse on scaler reload.
- txen, rxen, flow  out  1  copies of control TE, RE, FL.
- txtick, rxtick  out  1  one-cycle pulse per transmitted / sampled bit.

## Operation
Registers (offset):
- 0x0 data: write loads the TX holding register (THR). Read returns the RX byte and clears DR.
- 0x4 status: bit0 DR, bit1 TS (shifter empty), bit2 TE (THR empty), bit3 BR, bit4 OV, bit5 PE, bit6 FE. Writing 1 clears BR/OV/PE/FE; other bits are read-only. All other bits read 0.
- 0x8 control: bit0 RE, bit1 TE, bit2 RI, bit3 TI, bit4 PS (0 even / 1 odd), bit5 PE, bit6 FL, bit7 LB, bit8 EC.
- 0xC scaler: [const_sbits-1:0] reload value.

Baud generation:
- Scaler counts down on clk, or on synchronized extclk rising edges when EC=1. At 0 it reloads and pulses `scaler` (8x oversample tick).
- Bit time = 8 ticks = 8·(reload+1) clk.

Transmit:
- Frame: start 0, 8 data bits LSB first, parity if PE, stop 1.
- Starts when TE=1, THR full, shifter idle, and (FL=0 or synchronized ctsn=0).
- THR moves to the shifter at frame start, so TE status is set one clk later.

Receive:
- rxd passes through 2-FF synchronizer; LB=1 replaces rxd with internal txd.
- On a falling edge with RE=1, the bit is sampled at tick 4 of each bit. If the start bit is not 0 at mid-bit, the receiver aborts silently.
- At stop-bit mid, the byte is stored and DR is set.
- If DR was already 1: OV=1 and the old byte is kept.
- Stop bit 0: FE=1; if data and parity also all 0, BR=1.
- Parity mismatch: PE=1.

rtsn = FL & DR.

Interrupt: pirq_o[const_pirq] pulses one clk on byte received (RI=1), or on THR full→empty (TI=1).

APB:
- Write at psel & penable & pwrite.
- prdata is combinational from paddr[3:2] whenever the block is selected; otherwise 0.
- A data read clears DR on the access phase.

## Timing
- Reset values: all registers 0 except TS=TE=1 and TE/RE=const_console. Outputs: txd=1, rtsn=0, pirq_o=0, scaler/ticks=0, txen=rxen=flow=0 (const_console=0).
- Register write is visible on the next clk.
- Reset mid-frame aborts TX/RX immediately; txd=1.
- A write to THR while full overwrites the THR.
- A simultaneous DR set and data read: the set wins.

## Configuration
- APBUART_LOOPBACK_EN defined: LB bit implemented as described.
- Undefined: LB reads 0, writes ignored, no internal loop.

## Test plan
- Reset; write 0xFFFFFFFF to 0x4; read 0x4 → 0x00000006.
- Scaler=3, ctrl=0x3, data=0x55 → txd frame 0,1,0,1,0,1,0,1,0,1; 32 clk per bit; TS/TE return to 1.
- ctrl=0x23 (even parity), data=0x55 → parity bit 0 before stop.
- LB=1 (macro on), send 0xA5 → DR=1, read 0x0 = 0xA5, DR cleared, irq pulse with RI=1.
- Two received bytes without read → OV=1, data=first byte; write 0x10 to 0x4 clears OV.
- FL=1, ctsn=1, data written → txd stays 1; ctsn=0 → frame starts.
